datapath_sequencer: RTL
=======================

Name: datapath_sequencer

Overview:
- FSM controller that sequences the accumulator datapath: owns the program counter, fetches each instruction word from the combinational instruction memory, and decodes it into datapath strobes (load_a, load_b, sel_b, alu_op, literal).
- Adds conditional jumps on registered ALU flags, HALT, external run control, single-step, and a retired-instruction counter.
- Sits between the instruction memory and the regA/regB/muxB/ALU datapath; replaces the free-running PC.

Parameters:
- PC_W, 4, program counter width; instruction memory depth is 2^PC_W; legal range 1..8.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; leaves IDLE or HALTED and begins execution at pc=0.
- halt_req  in  1  level; requests a halt at the next instruction boundary.
- step_mode  in  1  1 = pause after every instruction.
- step  in  1  single-cycle pulse; releases one instruction while in PAUSE.
- instr  in  16  instruction word from memory, addressed by pc.
- alu_z, alu_n, alu_c  in  1 each  ALU zero, negative and carry, valid combinationally during EXEC.
- pc  out  PC_W  instruction memory address.
- load_a, load_b  out  1 each  register load strobes.
- sel_b  out  1  muxB select: 0 = regB, 1 = literal.
- alu_op  out  3  ALU operation select.
- literal  out  8  immediate operand.
- running  out  1  high in FETCH or EXEC.
- halted  out  1  high in HALTED.
- retired  out  CNT_W  count of executed instructions.

Behaviour:
- Encoding, instr[15]=0 (ALU op): [14] sel_b, [13] load_b, [12] load_a, [11:9] alu_op, [7:0] literal; [8] ignored.
- Encoding, instr[15]=1 (control): [14:12] cond, [PC_W-1:0] target.
  - cond values: 000 JMP, 001 JEQ (Z), 010 JNE (!Z), 011 JGT (!Z&!N), 100 JLT (N), 101 JGE (!N), 110 JCS (C), 111 HALT.
- States: IDLE, FETCH, EXEC, PAUSE, HALTED.
- Reset (async, immediate): state=IDLE, pc=0, ir=0, flags Z/N/C=0, retired=0. All strobes 0, literal=0, alu_op=0, running=0, halted=0.
- IDLE: when start=1, go to FETCH with pc=0.
- FETCH (1 cycle): register instr into ir, then go to EXEC.
- EXEC (1 cycle): outputs decode combinationally from ir.
  - load_a, load_b and sel_b are asserted only in EXEC; in all other states strobes=0, while alu_op and literal still reflect ir.
  - ALU op: pc <= pc+1, wrapping modulo 2^PC_W (last address to 0). If load_a|load_b, flags <= {alu_z, alu_n, alu_c}; otherwise flags hold.
  - Jump: pc <= target if the condition holds on the registered flags, else pc+1 (wrapping). Flags are unchanged.
  - HALT: pc holds; go to HALTED; retired increments.
  - Every EXEC increments retired, saturating at all-ones.
- Next state after a non-HALT EXEC, in priority order:
  - halt_req=1 → HALTED.
  - step_mode=1 → PAUSE.
  - otherwise → FETCH.
  - Throughput: 2 cycles per instruction.
- PAUSE: halt_req → HALTED; step=1 → FETCH; step_mode dropped to 0 → FETCH.
- HALTED: pc and flags hold; halted=1. start=1 → FETCH with pc=0, flags cleared, retired cleared.
- Simultaneous events:
  - halt_req beats start in IDLE/HALTED: remain, or enter, HALTED.
  - halt_req beats step in PAUSE.
  - start is ignored in FETCH, EXEC and PAUSE.
- Reset mid-EXEC: strobes drop immediately (asynchronously); no register load and no flag update occur on the next edge.
- Only one load per instruction per strobe; load_a and load_b may assert together.

Test Plan:
- Reset check: hold rst_n=0 across several clocks with random inputs → pc=0, all strobes 0, running=0, halted=0, retired=0. Release → remains IDLE until start.
- Straight-line: program {0x1200|0x05 (load_a, alu_op=1, sel_b=0), 0x6000|0x07 (sel_b=1, load_b)}, start pulse → load_a high exactly in cycle 3, load_b with literal=0x07 in cycle 5; pc 0→1→2; retired=2 after 4 cycles.
- Conditional jumps:
  - alu_z=1 during a loading EXEC, then JEQ target 9 → pc=9.
  - Same with alu_z=0 → pc=prev+1.
  - JGT with Z=0, N=1 → not taken.
- Halt: HALT at address 3 → halted=1, pc=3, retired=4. halt_req asserted at the same time as start → stays HALTED. start alone → restart at pc=0 with retired=0.
- Single-step: step_mode=1 → PAUSE after each EXEC; no strobes until step; 3 step pulses → exactly 3 retired; dropping step_mode resumes free run.
- Wrap and reset: ALU op at pc=15 (PC_W=4) → next pc=0. Assert rst_n=0 mid-EXEC → load_a falls before the clock edge; regA is unchanged.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Sequencer for the accumulator datapath: fetches from the instruction memory,
// decodes ALU/control words into datapath strobes and handles run/step/halt control.
module datapath_sequencer #(
  parameter int PC_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step_mode,
  input  logic             step,
  input  logic [15:0]      instr,
  input  logic             alu_z,
  input  logic             alu_n,
  input  logic             alu_c,
  output logic [PC_W-1:0]  pc,
  output logic             load_a,
  output logic             load_b,
  output logic             sel_b,
  output logic [2:0]       alu_op,
  output logic [7:0]       literal,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_PAUSE  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [15:0]     ir;
  logic            flag_z, flag_n, flag_c;
  logic            is_ctrl, is_halt, taken, restart;
  logic [2:0]      cond;
  logic [PC_W-1:0] pc_inc, target;
  logic            unused_ir_bit;

  assign is_ctrl       = ir[15];
  assign cond          = ir[14:12];
  assign is_halt       = is_ctrl && (cond == 3'b111);
  assign target        = ir[PC_W-1:0];
  assign pc_inc        = pc + PC_W'(1);
  assign unused_ir_bit = ir[8];
  // halt_req always wins over start when leaving IDLE or HALTED
  assign restart       = start && !halt_req;

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken = flag_z;
      3'b010:  taken = !flag_z;
      3'b011:  taken = !flag_z && !flag_n;
      3'b100:  taken = flag_n;
      3'b101:  taken = !flag_n;
      3'b110:  taken = flag_c;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    sel_b      = 1'b0;
    alu_op     = ir[11:9];
    literal    = ir[7:0];
    running    = 1'b0;
    halted     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = halt_req ? S_HALTED : S_FETCH;
      end
      S_FETCH: begin
        running    = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        running = 1'b1;
        load_a  = !is_ctrl && ir[12];
        load_b  = !is_ctrl && ir[13];
        sel_b   = !is_ctrl && ir[14];
        if (is_halt || halt_req) state_next = S_HALTED;
        else if (step_mode)      state_next = S_PAUSE;
        else                     state_next = S_FETCH;
      end
      S_PAUSE: begin
        if (halt_req)                state_next = S_HALTED;
        else if (step || !step_mode) state_next = S_FETCH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if (restart) state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_c  <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (restart) pc <= '0;
        end
        S_FETCH: ir <= instr;
        S_EXEC: begin
          if (retired != '1) retired <= retired + CNT_W'(1);
          if (!is_ctrl) begin
            pc <= pc_inc;
            if (ir[12] || ir[13]) begin
              flag_z <= alu_z;
              flag_n <= alu_n;
              flag_c <= alu_c;
            end
          end else if (!is_halt) begin
            pc <= taken ? target : pc_inc;
          end
        end
        S_HALTED: begin
          if (restart) begin
            pc      <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_c  <= 1'b0;
            retired <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
